// File: rtl/seq_mult_pkg.sv
// Shared definitions for the sequential left-shift multiplier.
package seq_mult_pkg;

   localparam int DEFAULT_WIDTH = 6;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

endpackage

// File: rtl/seq_mult_ls_param_if.sv
// Operand / result handshake bundle for the sequential multiplier.
interface seq_mult_ls_param_if #(parameter int WIDTH = 6);

   logic               in_valid;
   logic               in_ready;
   logic               signed_mode;
   logic [WIDTH-1:0]   a;
   logic [WIDTH-1:0]   b;
   logic               out_valid;
   logic               out_ready;
   logic [2*WIDTH-1:0] product;

   modport slave (
      input  in_valid, signed_mode, a, b, out_ready,
      output in_ready, out_valid, product
   );

   modport master (
      output in_valid, signed_mode, a, b, out_ready,
      input  in_ready, out_valid, product
   );

endinterface

// File: rtl/seq_mult_ctrl.sv
// Sequencing for the multiplier: accept, WIDTH shift-add steps, sign fix, hold.
//
//   state | meaning
//   IDLE  | waiting for operands, in_ready high
//   RUN   | one shift-add iteration per cycle, WIDTH cycles
//   FIX   | apply result sign, load product, raise out_valid
//   DONE  | product held until the consumer takes it
module seq_mult_ctrl
   import seq_mult_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
)
(
   input  logic clk,
   input  logic rst,
   input  logic in_valid,
   input  logic out_ready,
   output logic in_ready,
   output logic out_valid,
   output logic accept,
   output logic run_step,
   output logic fix_step
);

   localparam int              CW   = $clog2(WIDTH + 1);
   localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

   state_t        state;
   logic [CW-1:0] cnt;

   assign in_ready = (state == IDLE);
   assign accept   = in_valid && in_ready;
   assign run_step = (state == RUN);
   assign fix_step = (state == FIX);

   // State, iteration counter and registered out_valid.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         cnt       <= '0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  cnt   <= '0;
                  state <= RUN;
               end
            end
            RUN: begin
               if (cnt == LAST) begin
                  state <= FIX;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            FIX: begin
               out_valid <= 1'b1;
               state     <= DONE;
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: rtl/seq_mult_ls_param.sv
// Sequential sign/magnitude multiplier: MSB-first left-shift accumulate,
// sign applied once at the end so the iteration loop is purely unsigned.
module seq_mult_ls_param
   import seq_mult_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
)
(
   input  logic              clk,
   input  logic              rst,
   seq_mult_ls_param_if.slave bus
);

   localparam int PW = 2 * WIDTH;

   logic             accept;
   logic             run_step;
   logic             fix_step;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mplier;
   logic [PW-1:0]    acc;
   logic             sign;

   // Negating the most negative value wraps back to the same bit pattern,
   // which read as unsigned is exactly its magnitude.
   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x,
                                                  input logic is_signed);
      return (is_signed && x[WIDTH-1]) ? -x : x;
   endfunction

   seq_mult_ctrl #(.WIDTH(WIDTH)) u_ctrl (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (bus.in_valid),
      .out_ready (bus.out_ready),
      .in_ready  (bus.in_ready),
      .out_valid (bus.out_valid),
      .accept    (accept),
      .run_step  (run_step),
      .fix_step  (fix_step)
   );

   // Operand latch, shift-add iteration and signed product load.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mcand       <= '0;
         mplier      <= '0;
         acc         <= '0;
         sign        <= 1'b0;
         bus.product <= '0;
      end else begin
         if (accept) begin
            mcand  <= magnitude(bus.a, bus.signed_mode);
            mplier <= magnitude(bus.b, bus.signed_mode);
            sign   <= bus.signed_mode & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            acc    <= '0;
         end else if (run_step) begin
            acc    <= (acc << 1) + (mplier[WIDTH-1] ? PW'(mcand) : '0);
            mplier <= mplier << 1;
         end
         if (fix_step) begin
            bus.product <= sign ? -acc : acc;
         end
      end
   end

endmodule

// File: doc/seq_mult_ls_param.md
SEQ_MULT_LS_PARAM -- requirements
Module: seq_mult_ls_param

Interface
REQ-001 SHALL have parameter WIDTH, default 6, operand width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid  input  1  operands and mode presented.
REQ-005 SHALL have port in_ready  output  1  block can accept operands; high only in IDLE.
REQ-006 SHALL have port signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled on accept.
REQ-007 SHALL have port a  input  WIDTH  multiplicand.
REQ-008 SHALL have port b  input  WIDTH  multiplier.
REQ-009 SHALL have port out_valid  output  1  product valid, held until taken.
REQ-010 SHALL have port out_ready  input  1  consumer takes product.
REQ-011 SHALL have port product  output  2*WIDTH  result, two's-complement when signed_mode was 1.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, FIX, DONE; in_ready = (state == IDLE), combinational.
REQ-013 SHALL accept on rising edge with in_valid && in_ready: latch |a|, |b|, result sign (a_msb XOR b_msb when signed_mode, else 0), clear accumulator and iteration counter, go to RUN.
REQ-014 SHALL, in signed mode, form magnitudes by two's-complement negation of negative operands; magnitude of -2^(WIDTH-1) SHALL be 2^(WIDTH-1) (WIDTH-bit unsigned, no overflow).
REQ-015 SHALL, in RUN, perform one left-shift iteration per cycle, multiplier MSB first: acc <= (acc << 1) + (current multiplier bit ? multiplicand : 0), 2*WIDTH-bit accumulator, no truncation.
REQ-016 SHALL stay in RUN exactly WIDTH cycles, then enter FIX.
REQ-017 SHALL, in FIX, register product = sign ? -acc : acc (2*WIDTH bits), set out_valid, enter DONE.
REQ-018 SHALL assert out_valid exactly WIDTH+1 rising edges after the accepting edge, independent of operand values.
REQ-019 SHALL, in DONE, hold product and out_valid stable while out_ready is low.
REQ-020 SHALL, on edge with out_valid && out_ready, clear out_valid and return to IDLE; no new accept on that same edge (in_ready low in DONE).
REQ-021 SHALL ignore in_valid, a, b, signed_mode outside IDLE; input changes mid-computation SHALL not affect the result.
REQ-022 SHALL keep product at its last value after handshake until the next FIX overwrites it.
REQ-023 SHALL produce a zero product (no negative zero) when either operand is zero in either mode.

Reset
REQ-024 SHALL, while rst is low, force state IDLE, out_valid 0, product 0, accumulator/counter/sign 0, independent of clk.
REQ-025 SHALL hold in_ready 1 during and after reset (state IDLE).
REQ-026 SHALL abort any computation in progress when rst falls; no partial product SHALL ever appear with out_valid 1.
REQ-027 SHALL accept operands on the first rising edge after rst deasserts when in_valid is high.

Structure
REQ-028 SHALL place state encoding (2-bit IDLE=0, RUN=1, FIX=2, DONE=3) and default WIDTH constant in shared package seq_mult_pkg.
REQ-029 SHALL split FSM and counter into sub-module seq_mult_ctrl; datapath (magnitude, shift-add, negate) stays in top level.
REQ-030 SHALL size the iteration counter as clog2(WIDTH+1) bits.

Verification (WIDTH=6)
REQ-031 Unsigned: a=57, b=32, signed_mode=0, out_ready=1 -> product=1824 (0x720), out_valid exactly 7 edges after accept, high one cycle.
REQ-032 Signed: a=-3 (0x3D), b=5, signed_mode=1 -> product=0xFF1 (-15); a=-32, b=-32 -> product=1024 (0x400).
REQ-033 Extremes: unsigned a=63, b=63 -> 3969 (0xF81); signed a=-32, b=31 -> 0xC20 (-992); a=0, b=-1 signed -> 0x000.
REQ-034 Backpressure: out_ready low 5 cycles after out_valid -> product/out_valid stable, in_ready low, new in_valid ignored; accepted only after handshake.
REQ-035 Reset mid-run: rst low 3 cycles after accept of 57*32 -> out_valid 0, product 0, in_ready 1 immediately; next accept of 7*9 -> 63 after 7 edges.
REQ-036 Input disturbance: change a, b, signed_mode every cycle during RUN -> result equals operands latched at accept.
